multicycle_control: RTL and testbench

- Moore-style FSM that sequences the multicycle MIPS datapath: one shared memory, one ALU, IR/MDR/A/B/ALUOut registers.
- Steps each instruction through fetch, decode, execute, memory and write-back cycles, driving mux selects and write enables.
- Waits on a memory-ready handshake and traps unsupported opcodes.
- Sits beside the datapath top; takes the opcode from IR and Zero from the ALU.

---
 rtl/mc_ctrl_pkg.sv | 76 +++++++
 rtl/multicycle_output_decode.sv | 75 +++++++
 rtl/multicycle_control.sv | 139 +++++++++++++
 tb/tb_multicycle_control.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS controller.
// Opcodes, state codes, mux select codes and the control vector.
package mc_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] LUI    = 6'h0f;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] J      = 6'h02;

  localparam logic [5:0] ALU_ADD = 6'h08;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [5:0] aluOp;
  } ctrl_t;

  // Successor of DECODE; FETCH means the opcode is unsupported.
  function automatic state_t decodeNext(input logic [5:0] op);
    state_t nxt;
    nxt = FETCH;
    unique case (1'b1)
      (op == R_TYPE):
        nxt = EXEC_R;
      (op == ADDI) || (op == ORI) || (op == LUI):
        nxt = EXEC_I;
      (op == LW) || (op == SW):
        nxt = MEM_ADDR;
      (op == BEQ) || (op == BNE):
        nxt = BRANCH;
      (op == J):
        nxt = JUMP;
      default:
        nxt = FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Moore control-vector decode from the registered state.
// Only PCWrite/IRWrite look at MemReady or Zero.
module multicycle_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opQ,
  input  logic       Zero,
  input  logic       MemReady,
  output ctrl_t      ctrl
);

  // Per-state mux selects, strobes and enables.
  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.irWrite = MemReady;
        ctrl.pcWrite = MemReady;
      end
      DECODE: begin
        ctrl.aluSrcB = SRCB_IMM_SH;
        ctrl.aluOp   = ALU_ADD;
      end
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.iorD    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      MEM_WB: begin
        ctrl.memtoReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      MEM_WR: begin
        ctrl.iorD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = R_TYPE;
      end
      EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = opQ;
      end
      ALU_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = (opQ == R_TYPE);
      end
      BRANCH: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = SRCB_REG;
        ctrl.aluOp    = opQ;
        ctrl.pcSource = PCSRC_ALUOUT;
        ctrl.pcWrite  = ((opQ == BEQ) && Zero)
                     || ((opQ == BNE) && !Zero);
      end
      JUMP: begin
        ctrl.pcSource = PCSRC_JUMP;
        ctrl.pcWrite  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake timeout.
// Define MC_RETIRE_COUNT_EN to build the retired-instruction counter.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OP,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [5:0]       ALUOp,
  output logic             MemTimeout,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetireCount
);

  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  state_t     state;
  logic [5:0] opQ;
  logic [7:0] waitCnt;
  ctrl_t      ctrl;
  logic       memState;
  logic       waitHit;
  logic       illegal;

  assign memState = (state == FETCH)
                 || (state == MEM_RD)
                 || (state == MEM_WR);

  // Limit reached while memory still busy: give up.
  assign waitHit = memState && !MemReady
                && (waitCnt == WMAX);

  assign illegal = (state == DECODE)
                && (decodeNext(OP) == FETCH);

  // State sequencing, opcode latch and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      opQ     <= '0;
      waitCnt <= '0;
    end else begin
      if (memState && !MemReady && !waitHit)
        waitCnt <= waitCnt + 8'd1;
      else
        waitCnt <= '0;

      unique case (state)
        FETCH:
          state <= MemReady ? DECODE : FETCH;
        DECODE: begin
          opQ   <= OP;
          state <= decodeNext(OP);
        end
        MEM_ADDR:
          state <= (opQ == LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (MemReady)
            state <= MEM_WB;
          else if (waitHit)
            state <= FETCH;
        end
        MEM_WR: begin
          if (MemReady || waitHit)
            state <= FETCH;
        end
        EXEC_R:
          state <= ALU_WB;
        EXEC_I:
          state <= ALU_WB;
        default:
          state <= FETCH;
      endcase
    end
  end

  multicycle_output_decode uDecode (
    .state    (state),
    .opQ      (opQ),
    .Zero     (Zero),
    .MemReady (MemReady),
    .ctrl     (ctrl)
  );

  assign PCWrite    = ctrl.pcWrite  & ~reset;
  assign IRWrite    = ctrl.irWrite  & ~reset;
  assign RegWrite   = ctrl.regWrite & ~reset;
  assign MemRead    = ctrl.memRead  & ~reset;
  assign MemWrite   = ctrl.memWrite & ~reset;
  assign MemTimeout = waitHit       & ~reset;
  assign IllegalOp  = illegal       & ~reset;

  assign IorD     = ctrl.iorD;
  assign MemtoReg = ctrl.memtoReg;
  assign RegDst   = ctrl.regDst;
  assign ALUSrcA  = ctrl.aluSrcA;
  assign ALUSrcB  = ctrl.aluSrcB;
  assign PCSource = ctrl.pcSource;
  assign ALUOp    = ctrl.aluOp;
  assign State    = state;

`ifdef MC_RETIRE_COUNT_EN
  logic retire;

  assign retire = (state == MEM_WB)
               || (state == ALU_WB)
               || (state == BRANCH)
               || (state == JUMP)
               || ((state == MEM_WR) && MemReady);

  // Count completed instructions; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)
      RetireCount <= '0;
    else if (retire)
      RetireCount <= RetireCount + CNT_W'(1);
  end
`else
  assign RetireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Per-instruction summaries from a reference model vs observed.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       OP = '0;
  logic             Zero = 1'b0;
  logic             MemReady = 1'b0;
  logic             PCWrite, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, PCSource;
  logic [5:0]       ALUOp;
  logic             MemTimeout, IllegalOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] RetireCount;

  multicycle_control #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .OP          (OP),
    .Zero        (Zero),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .MemTimeout  (MemTimeout),
    .IllegalOp   (IllegalOp),
    .State       (State),
    .RetireCount (RetireCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         fw;
    int         mw;
  } instr_t;

  typedef struct {
    int          cycles;
    logic [63:0] path;
    int          irw, pcw, regw, rdst, m2r;
    int          memw, ill, to, ret;
  } obs_t;

  instr_t instrQ[$];
  obs_t   expQ[$];
  int     total = 0;
  int     bad = 0;
  int     closed = 0;
  bit     run = 0;
  bit     monEn = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addInstr(input logic [5:0] op, input logic z,
                          input int fw, input int mw);
    instr_t t;
    t.op = op; t.zero = z; t.fw = fw; t.mw = mw;
    instrQ.push_back(t);
  endtask

  function automatic logic [63:0] addPath(input logic [63:0] p,
                                          input int s);
    return (p << 4) | 64'(s + 1);
  endfunction

  // Reference: what one instruction should do, from its class,
  // its memory latencies and the handshake limit.
  function automatic obs_t model(input instr_t in);
    obs_t e;
    e = '{default: 0};
    e.path = addPath(64'd0, 0);
    if (in.fw > WAIT_MAX) begin
      e.cycles = WAIT_MAX + 1;
      e.to = 1;
      return e;
    end
    e.cycles = in.fw + 2;
    e.irw = 1;
    e.pcw = 1;
    e.path = addPath(e.path, 1);
    case (in.op)
      6'h00: begin
        e.path = addPath(addPath(e.path, 6), 8);
        e.cycles += 2; e.regw = 1; e.rdst = 1; e.ret = 1;
      end
      6'h08, 6'h0d, 6'h0f: begin
        e.path = addPath(addPath(e.path, 7), 8);
        e.cycles += 2; e.regw = 1; e.ret = 1;
      end
      6'h23: begin
        e.path = addPath(addPath(e.path, 2), 3);
        e.cycles += 1;
        if (in.mw > WAIT_MAX) begin
          e.cycles += WAIT_MAX + 1; e.to = 1;
        end else begin
          e.cycles += in.mw + 2;
          e.path = addPath(e.path, 4);
          e.regw = 1; e.m2r = 1; e.ret = 1;
        end
      end
      6'h2b: begin
        e.path = addPath(addPath(e.path, 2), 5);
        e.cycles += 1;
        if (in.mw > WAIT_MAX) begin
          e.cycles += WAIT_MAX + 1; e.to = 1;
        end else begin
          e.cycles += in.mw + 1; e.memw = 1; e.ret = 1;
        end
      end
      6'h04, 6'h05: begin
        e.path = addPath(e.path, 9);
        e.cycles += 1; e.ret = 1;
        if ((in.op == 6'h04) ? in.zero : !in.zero) e.pcw += 1;
      end
      6'h02: begin
        e.path = addPath(e.path, 10);
        e.cycles += 1; e.pcw += 1; e.ret = 1;
      end
      default: e.ill = 1;
    endcase
`ifndef MC_RETIRE_COUNT_EN
    e.ret = 0;
`endif
    return e;
  endfunction

  // Driver: memory responder plus opcode source.
  initial begin : driver
    instr_t cur;
    bit     started;
    int     acc;
    int     prevState;
    bit     prevTo;
    int     lat;
    started = 0; acc = 0; prevState = -1; prevTo = 0;
    cur.op = 6'h00; cur.zero = 1'b0; cur.fw = 0; cur.mw = 0;
    forever begin
      @(posedge clk); #2;
      if (!run) begin
        started = 0; prevState = -1; prevTo = 0;
        continue;
      end
      if (State == 4'd0 && (!started || prevState != 0 || prevTo)) begin
        started = 1;
        if (instrQ.size() > 0) begin
          cur = instrQ.pop_front();
          expQ.push_back(model(cur));
        end else begin
          cur.op = 6'h00; cur.zero = 1'b0; cur.fw = 0; cur.mw = 0;
        end
        acc = 0;
      end else if (int'(State) != prevState) begin
        acc = 0;
      end
      OP = cur.op;
      if (MemRead || MemWrite) begin
        lat = IorD ? cur.mw : cur.fw;
        MemReady = (acc >= lat);
        if (!MemReady) acc++;
      end else begin
        MemReady = 1'($urandom_range(0, 1));
      end
      if (cur.op == 6'h04 || cur.op == 6'h05)
        Zero = cur.zero;
      else
        Zero = 1'($urandom_range(0, 1));
      #1;
      prevTo = MemTimeout;
      prevState = int'(State);
    end
  end

  // Monitor: summarise each instruction, compare against queue.
  initial begin : monitor
    obs_t             o;
    obs_t             e;
    bit               active;
    int               prevState;
    bit               prevTo;
    logic [3:0]       lastS;
    logic [CNT_W-1:0] rc0;
    string            tag;
    active = 0; prevState = -1; prevTo = 0; lastS = 4'hf; rc0 = '0;
    o = '{default: 0};
    forever begin
      @(negedge clk);
      if (!monEn) begin
        active = 0; prevState = -1; prevTo = 0;
        continue;
      end
      if (State == 4'd0 && (!active || prevState != 0 || prevTo)) begin
        if (active && expQ.size() > 0) begin
          o.ret = int'(RetireCount - rc0);
          e = expQ.pop_front();
          tag = $sformatf("i%0d", closed);
          closed++;
          check({tag, "_cycles"}, 64'(o.cycles), 64'(e.cycles));
          check({tag, "_path"}, o.path, e.path);
          check({tag, "_irwrite"}, 64'(o.irw), 64'(e.irw));
          check({tag, "_pcwrite"}, 64'(o.pcw), 64'(e.pcw));
          check({tag, "_regwrite"}, 64'(o.regw), 64'(e.regw));
          check({tag, "_regdst"}, 64'(o.rdst), 64'(e.rdst));
          check({tag, "_memtoreg"}, 64'(o.m2r), 64'(e.m2r));
          check({tag, "_memwrite"}, 64'(o.memw), 64'(e.memw));
          check({tag, "_illegal"}, 64'(o.ill), 64'(e.ill));
          check({tag, "_timeout"}, 64'(o.to), 64'(e.to));
          check({tag, "_retire"}, 64'(o.ret), 64'(e.ret));
        end
        o = '{default: 0};
        lastS = 4'hf;
        rc0 = RetireCount;
        active = 1;
      end
      o.cycles++;
      if (State !== lastS) begin
        o.path = addPath(o.path, int'(State));
        lastS = State;
      end
      o.irw  += int'(IRWrite);
      o.pcw  += int'(PCWrite);
      o.regw += int'(RegWrite);
      o.rdst += int'(RegWrite && RegDst);
      o.m2r  += int'(RegWrite && MemtoReg);
      o.memw += int'(MemWrite && MemReady);
      o.ill  += int'(IllegalOp);
      o.to   += int'(MemTimeout);
      prevState = int'(State);
      prevTo = MemTimeout;
    end
  end

  initial begin : main
    logic [5:0] opTab [10];
    int         n;
    int         pick;
    logic [5:0] op;
    int         fw, mw;
    opTab = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23,
              6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f};

    addInstr(6'h23, 1'b0, 0, 0);
    addInstr(6'h04, 1'b1, 0, 0);
    addInstr(6'h05, 1'b1, 0, 0);
    addInstr(6'h2b, 1'b0, 0, 0);
    addInstr(6'h00, 1'b0, 0, 0);
    addInstr(6'h0d, 1'b0, 0, 0);
    addInstr(6'h02, 1'b0, 0, 0);
    addInstr(6'h00, 1'b0, WAIT_MAX + 3, 0);
    addInstr(6'h08, 1'b0, WAIT_MAX, 0);
    addInstr(6'h23, 1'b0, 1, WAIT_MAX + 1);
    addInstr(6'h2b, 1'b0, 0, WAIT_MAX);
    addInstr(6'h2b, 1'b0, 2, WAIT_MAX + 5);
    addInstr(6'h3f, 1'b0, 0, 0);
    for (int k = 0; k < 50; k++) begin
      pick = $urandom_range(0, 10);
      op = (pick == 10) ? 6'($urandom_range(0, 63)) : opTab[pick];
      fw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3)
                                      : $urandom_range(0, WAIT_MAX + 2);
      mw = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3)
                                      : $urandom_range(0, WAIT_MAX + 2);
      addInstr(op, 1'($urandom_range(0, 1)), fw, mw);
    end
    n = instrQ.size();

    reset = 1'b1;
    MemReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_enables",
            64'({PCWrite, IRWrite, RegWrite, MemRead,
                 MemWrite, MemTimeout, IllegalOp}), 64'd0);
      check("rst_state", 64'(State), 64'd0);
    end
    check("rst_retire", 64'(RetireCount), 64'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    run = 1;
    monEn = 1;
    @(negedge clk);
    check("post_rst_memread", 64'(MemRead), 64'd1);
    check("post_rst_iord", 64'(IorD), 64'd0);
    check("post_rst_srcb", 64'(ALUSrcB), 64'd1);

    for (int k = 0; k < 4000 && closed < n; k++) @(posedge clk);
    check("drain", 64'(closed), 64'(n));

    @(posedge clk); #1;
    run = 0;
    monEn = 0;
    reset = 1'b1;
    MemReady = 1'b1;
    OP = 6'h2b;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (State == 4'd5) break;
      @(posedge clk); #1;
    end
    check("reach_memwr", 64'(State), 64'd5);
    MemReady = 1'b0;
    #1;
    check("memwr_strobe", 64'(MemWrite), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("memwr_rst_gate", 64'(MemWrite), 64'd0);
    @(negedge clk);
    check("memwr_rst_state", 64'(State), 64'd0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
